alu_mult_seq: RTL and testbench

Sequencer that computes a 32x32 signed multiply by driving the shared 32-bit ALU through 32 radix-2 Booth steps. It owns the partial-product state (A, Q, Q-1, step counter), requests the ALU only on steps that need an add or subtract, and stalls while the pipeline holds the ALU. It sits beside the execute stage and returns the low 32 bits of the product plus an overflow exception flag.

---
 rtl/alu_mult_seq.sv | 79 +++++++
 tb/tb_alu_mult_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: 32x32 signed radix-2 Booth multiplier sequenced over the shared ALU.
// Returns the low product word plus a signed-32 overflow flag.
module alu_mult_seq (
   input  logic        clock,
   input  logic        ctrl_reset_n,
   input  logic        ctrl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy,
   output logic        alu_req,
   input  logic        alu_gnt,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   output logic [4:0]  alu_opcode,
   output logic [4:0]  alu_shiftamt,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow
);
   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] a, q, m, sum, a_nxt, q_nxt;
   logic [4:0] count;
   logic q_1, s, need_alu, adv, last, start;
   assign need_alu = q[0] ^ q_1;
   assign start = ctrl_MULT && state != STEP;
   assign adv = state == STEP && (!need_alu || alu_gnt);
   assign last = adv && count == 5'd31;
   assign sum = need_alu ? alu_result : a;
   // true 33-bit sign of the add/sub; keeps M = 0x80000000 exact with a 32-bit A
   assign s = need_alu ? alu_result[31] ^ alu_overflow : a[31];
   assign a_nxt = {s, sum[31:1]};
   assign q_nxt = {sum[0], q[31:1]};
   assign alu_operandA = a;
   assign alu_operandB = m;
   assign alu_shiftamt = 5'b00000;
   always_ff @(posedge clock or negedge ctrl_reset_n)
      if (!ctrl_reset_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (state == STEP) state_nxt = last ? DONE : STEP;
      else state_nxt = ctrl_MULT ? STEP : IDLE;
   end
   always_comb begin
      busy = state == STEP;
      data_resultRDY = state == DONE;
      alu_req = busy && need_alu;
      alu_opcode = alu_req ? {4'b0000, q[0]} : 5'b00000;
   end
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         a <= '0;
         q <= '0;
         q_1 <= 1'b0;
         m <= '0;
         count <= '0;
         data_result <= '0;
         data_exception <= 1'b0;
      end else if (start) begin
         m <= data_operandA;
         q <= data_operandB;
         a <= '0;
         q_1 <= 1'b0;
         count <= '0;
      end else if (adv) begin
         a <= a_nxt;
         q <= q_nxt;
         q_1 <= q[0];
         count <= count + 5'd1;
         if (last) begin
            data_result <= q_nxt;
            data_exception <= a_nxt != {32{q_nxt[31]}};
         end
      end
   end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_alu_mult_seq;
   logic        clock = 1'b0;
   logic        ctrl_reset_n, ctrl_MULT;
   logic [31:0] data_operandA, data_operandB, data_result;
   logic        data_exception, data_resultRDY, busy, alu_req, alu_gnt, alu_overflow;
   logic [31:0] alu_operandA, alu_operandB, alu_result;
   logic [4:0]  alu_opcode, alu_shiftamt;
   int checks = 0, errors = 0, cyc = 0, stall_n = 0, stall_cnt = 0;
   logic prev_rdy = 1'b0;
   typedef struct {logic [31:0] res; logic exc; int lat; int t0;} exp_t;
   exp_t sb[$];
   exp_t mon_e;

   alu_mult_seq dut (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n), .ctrl_MULT(ctrl_MULT),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy), .alu_req(alu_req),
      .alu_gnt(alu_gnt), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
      .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
      .alu_result(alu_result), .alu_overflow(alu_overflow)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // shared ALU stand-in: add/sub with signed overflow, grant withheld stall_n cycles per request
   assign alu_result = alu_opcode[0] ? alu_operandA - alu_operandB : alu_operandA + alu_operandB;
   assign alu_overflow = alu_opcode[0]
      ? (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31])
      : (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
   assign alu_gnt = stall_cnt >= stall_n;
   always @(posedge clock)
      if (alu_req && !alu_gnt) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (data_resultRDY) begin
         chk("rdy_pulse_len", 32'(prev_rdy), 32'd0);
         if (sb.size() == 0) chk("unexpected_rdy", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("result", data_result, mon_e.res);
            chk("exception", 32'(data_exception), 32'(mon_e.exc));
            chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
         end
      end
      prev_rdy <= data_resultRDY;
   end

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input logic exc, input int lat, input bit now, input bit push);
      if (!now) @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = 1'b1;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      if (push) sb.push_back('{res, exc, lat, cyc});
   endtask

   // follows the Booth steps of multiplier b until RDY; optional mid-STEP start pulse or reset
   task automatic run(input logic [31:0] b, input int exp_busy, input int pulse_at, input int rst_at);
      int k, busy_n;
      logic [31:0] held_a;
      logic stalled, exp_req;
      k = 0;
      busy_n = 0;
      stalled = 1'b0;
      held_a = '0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         ctrl_MULT = (n == pulse_at);
         if (n == pulse_at) begin
            data_operandA = 32'd100;
            data_operandB = 32'd100;
         end
         if (n == rst_at) begin
            #3 ctrl_reset_n = 1'b0;
            #1;
            chk("rst_result", data_result, 32'd0);
            chk("rst_exception", 32'(data_exception), 32'd0);
            chk("rst_rdy", 32'(data_resultRDY), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_alu_req", 32'(alu_req), 32'd0);
            chk("rst_operandA", alu_operandA, 32'd0);
            chk("rst_operandB", alu_operandB, 32'd0);
            return;
         end
         if (data_resultRDY) break;
         if (busy) begin
            busy_n++;
            if (stalled) chk("stall_hold_A", alu_operandA, held_a);
            exp_req = k < 32 && (b[k] ^ (k > 0 ? b[k-1] : 1'b0));
            chk("alu_req", 32'(alu_req), 32'(exp_req));
            if (alu_req && k < 32) chk("alu_opcode", 32'(alu_opcode), 32'(b[k]));
            stalled = alu_req && !alu_gnt;
            held_a = alu_operandA;
            if (!stalled) k++;
         end
      end
      if (!data_resultRDY) chk("timeout_rdy", 32'd0, 32'd1);
      if (exp_busy >= 0) chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
   endtask

   initial begin
      ctrl_reset_n = 1'b0;
      ctrl_MULT = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      #1;
      chk("init_result", data_result, 32'd0);
      chk("init_exception", 32'(data_exception), 32'd0);
      chk("init_rdy", 32'(data_resultRDY), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_alu_req", 32'(alu_req), 32'd0);
      chk("init_shiftamt", 32'(alu_shiftamt), 32'd0);
      repeat (2) @(negedge clock);
      ctrl_reset_n = 1'b1;
      start(32'd3, 32'd4, 32'h0000000C, 1'b0, 32, 0, 1);
      run(32'd4, 32, -1, -1);
      start(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, 32, 0, 1);
      run(32'd6, 32, -1, -1);
      start(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 32, 0, 1);
      run(32'd2, 32, -1, -1);
      start(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32, 0, 1);
      run(32'hFFFFFFFF, 32, -1, -1);
      start(32'h80000000, 32'd1, 32'h80000000, 1'b0, 32, 0, 1);
      run(32'd1, 32, -1, -1);
      stall_n = 3;
      start(32'd15, 32'd5, 32'h0000004B, 1'b0, 44, 0, 1);
      run(32'd5, 44, -1, -1);
      stall_n = 0;
      start(32'd5, 32'hFFFFFFFD, 32'hFFFFFFF1, 1'b0, 32, 0, 1);
      run(32'hFFFFFFFD, 32, 5, -1);
      start(32'd6, 32'd7, 32'd42, 1'b0, 32, 0, 1);
      run(32'd7, 32, -1, -1);
      start(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32, 1, 1);
      run(32'h00010000, 32, -1, -1);
      start(32'd3, 32'd4, 32'd0, 1'b0, 0, 0, 0);
      run(32'd4, -1, -1, 10);
      repeat (3) begin
         @(negedge clock);
         chk("rst_no_rdy", 32'(data_resultRDY), 32'd0);
      end
      ctrl_reset_n = 1'b1;
      start(32'd3, 32'd4, 32'h0000000C, 1'b0, 32, 0, 1);
      run(32'd4, 32, -1, -1);
      repeat (2) @(negedge clock);
      chk("pending", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
